// File: rtl/spi_flash_okuyucu_if.sv
// Register-port bus between the flash reader (master) and the SPI controller (slave).
interface spi_flash_okuyucu_if;
  logic [4:0]  at_adres_c;
  logic [31:0] at_yaz_veri_c;
  logic        at_yaz_gecerli_c;
  logic        at_gecerli_c;
  logic [31:0] at_oku_veri_g;
  logic        at_oku_gecerli_g;
  logic        at_mesgul_g;

  modport master (
    output at_adres_c, at_yaz_veri_c, at_yaz_gecerli_c, at_gecerli_c,
    input  at_oku_veri_g, at_oku_gecerli_g, at_mesgul_g
  );

  modport slave (
    input  at_adres_c, at_yaz_veri_c, at_yaz_gecerli_c, at_gecerli_c,
    output at_oku_veri_g, at_oku_gecerli_g, at_mesgul_g
  );
endinterface

// File: rtl/spi_flash_okuyucu.sv
// SPI flash reader: turns one (address, word count) request into a 0x03 READ
// sequence on the SPI controller's register port and streams the words out.
module spi_flash_okuyucu #(
  parameter logic [15:0] SCK_DIV    = 16'd5,
  parameter logic [4:0]  PARK_ADRES = 5'h14
) (
  input  logic                 clk_g,
  input  logic                 rst_g,
  input  logic                 istek_gecerli,
  output logic                 istek_hazir,
  input  logic [23:0]          istek_adres,
  input  logic [6:0]           istek_sayi,
  output logic [31:0]          veri,
  output logic                 veri_gecerli,
  input  logic                 veri_hazir,
  output logic                 bitti,
  spi_flash_okuyucu_if.master  at
);

  localparam logic [4:0]  A_CTRL   = 5'h00;
  localparam logic [4:0]  A_STATUS = 5'h04;
  localparam logic [4:0]  A_RDATA  = 5'h08;
  localparam logic [4:0]  A_WDATA  = 5'h0C;
  localparam logic [4:0]  A_CMD    = 5'h10;

  localparam logic [31:0] CTRL_CFG      = {SCK_DIV, 12'h000, 4'b0001};
  localparam logic [31:0] CTRL_SOFT_RST = 32'h0000_0002;
  localparam logic [31:0] CMD_TX_VAL    = 32'h0000_2204;

  typedef enum logic [9:0] {
    IDLE     = 10'b00_0000_0001,
    CTRL_WR  = 10'b00_0000_0010,
    WDATA_WR = 10'b00_0000_0100,
    CMD_TX   = 10'b00_0000_1000,
    POLL_TX  = 10'b00_0001_0000,
    CMD_RX   = 10'b00_0010_0000,
    POLL_RX  = 10'b00_0100_0000,
    RD       = 10'b00_1000_0000,
    FLUSH    = 10'b01_0000_0000,
    DONE     = 10'b10_0000_0000
  } state_t;

  state_t      state, state_n;
  logic        ack_faz, ack_faz_n;   // 0: request cycle, 1: ack cycle of an acked access
  logic        mesgul_r;             // controller busy as seen in the request cycle
  logic [23:0] adres_r;
  logic [6:0]  sayi_r;
  logic [6:0]  sayac;
  logic        erisim_ok;
  logic        yukle;
  logic        gec, yaz;
  logic [4:0]  adr;
  logic [31:0] yveri;
  logic [8:0]  rx_len;

  assign erisim_ok = ack_faz && at.at_oku_gecerli_g && !mesgul_r;
  assign rx_len    = {sayi_r, 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      state   <= IDLE;
      ack_faz <= 1'b0;
    end else begin
      state   <= state_n;
      ack_faz <= ack_faz_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    ack_faz_n   = 1'b0;
    yukle       = 1'b0;
    gec         = 1'b0;
    yaz         = 1'b0;
    adr         = PARK_ADRES;
    yveri       = '0;
    istek_hazir = 1'b0;
    bitti       = 1'b0;

    unique case (state)
      IDLE: begin
        istek_hazir = 1'b1;
        if (istek_gecerli) state_n = CTRL_WR;
      end
      CTRL_WR: begin
        if (!ack_faz) begin
          gec = 1'b1; yaz = 1'b1; adr = A_CTRL; yveri = CTRL_CFG; ack_faz_n = 1'b1;
        end else if (erisim_ok) begin
          state_n = WDATA_WR;
        end
      end
      WDATA_WR: begin
        if (!ack_faz) begin
          gec = 1'b1; yaz = 1'b1; adr = A_WDATA; yveri = {8'h03, adres_r}; ack_faz_n = 1'b1;
        end else if (erisim_ok) begin
          state_n = CMD_TX;
        end
      end
      CMD_TX: begin
        // Entered only straight after an acked access, so the controller can take it.
        gec = 1'b1; yaz = 1'b1; adr = A_CMD; yveri = CMD_TX_VAL;
        state_n = POLL_TX;
      end
      POLL_TX: begin
        if (!ack_faz) begin
          gec = 1'b1; adr = A_STATUS; ack_faz_n = 1'b1;
        end else if (erisim_ok && at.at_oku_veri_g[2]) begin
          state_n = CMD_RX;
        end
      end
      CMD_RX: begin
        gec = 1'b1; yaz = 1'b1; adr = A_CMD;
        yveri = {19'h0, 1'b1, 2'b00, 1'b1, rx_len};
        state_n = POLL_RX;
      end
      POLL_RX: begin
        // Holding off on a full output slot lets the controller FIFO stall the SPI clock.
        if (!ack_faz) begin
          gec = 1'b1; adr = A_STATUS; ack_faz_n = 1'b1;
        end else if (erisim_ok && !at.at_oku_veri_g[3] && !veri_gecerli) begin
          state_n = RD;
        end
      end
      RD: begin
        if (!ack_faz) begin
          gec = 1'b1; adr = A_RDATA; ack_faz_n = 1'b1;
        end else if (erisim_ok) begin
          yukle = 1'b1;
          if (7'(sayac + 7'd1) == sayi_r) state_n = FLUSH;
          else                            state_n = POLL_RX;
        end
      end
      FLUSH: begin
        if (!veri_gecerli) begin
          gec = 1'b1; yaz = 1'b1; adr = A_CTRL; yveri = CTRL_SOFT_RST;
          state_n = DONE;
        end
      end
      DONE: begin
        bitti   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      adres_r      <= '0;
      sayi_r       <= '0;
      sayac        <= '0;
      mesgul_r     <= 1'b0;
      veri         <= '0;
      veri_gecerli <= 1'b0;
    end else begin
      mesgul_r <= at.at_mesgul_g;
      if (state == IDLE && istek_gecerli) begin
        adres_r <= istek_adres;
        sayi_r  <= (istek_sayi == 7'd0) ? 7'd1 : istek_sayi;
        sayac   <= '0;
      end
      if (veri_gecerli && veri_hazir) veri_gecerli <= 1'b0;
      if (yukle) begin
        veri         <= at.at_oku_veri_g;
        veri_gecerli <= 1'b1;
        sayac        <= sayac + 7'd1;
      end
    end
  end

  assign at.at_adres_c       = adr;
  assign at.at_yaz_veri_c    = yveri;
  assign at.at_yaz_gecerli_c = yaz;
  assign at.at_gecerli_c     = gec;

endmodule

// File: tb/tb_spi_flash_okuyucu.sv
// Self-checking bench: behavioural SPI controller + flash on the register port,
// a random-ready consumer and a scoreboard of expected words and bus writes.
module tb_spi_flash_okuyucu;

  localparam logic [4:0] A_CTRL = 5'h00, A_STATUS = 5'h04, A_RDATA = 5'h08,
                         A_WDATA = 5'h0C, A_CMD = 5'h10, A_PARK = 5'h14;

  logic        clk_g = 1'b0;
  logic        rst_g = 1'b0;
  logic        istek_gecerli = 1'b0;
  logic        istek_hazir;
  logic [23:0] istek_adres = '0;
  logic [6:0]  istek_sayi = '0;
  logic [31:0] veri;
  logic        veri_gecerli;
  logic        veri_hazir;
  logic        bitti;

  spi_flash_okuyucu_if at_if ();

  spi_flash_okuyucu dut (
    .clk_g         (clk_g),
    .rst_g         (rst_g),
    .istek_gecerli (istek_gecerli),
    .istek_hazir   (istek_hazir),
    .istek_adres   (istek_adres),
    .istek_sayi    (istek_sayi),
    .veri          (veri),
    .veri_gecerli  (veri_gecerli),
    .veri_hazir    (veri_hazir),
    .bitti         (bitti),
    .at            (at_if)
  );

  always #5 clk_g = ~clk_g;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and controller model state
  logic [31:0] mosi_q[$], miso_q[$], slave_words[$], exp_q[$];
  logic [36:0] wr_log[$];
  int  tx_cnt = 0, rx_words = 0, rx_cnt = 0;
  bit  pend = 0, pend_ack = 0;
  logic [31:0] pend_data = '0;
  bit  busy_en = 0, drop_wdata = 0, hold = 0;
  int  wdata_req_cnt = 0, wdata_done_cnt = 0, rdata_req_cnt = 0;
  int  park_err = 0, rd_full_err = 0, stab_err = 0, hazir_err = 0, extra_err = 0;
  int  n_rx = 0, n_bitti = 0, rx_at_bitti = -1;
  int  cur_k = 0;
  logic [23:0] cur_adr = '0;

  // Behavioural SPI controller: one-cycle request, response on the following cycle.
  always @(negedge clk_g) begin
    logic [4:0]  a;
    logic [31:0] d;
    bit          busy;
    if (!rst_g) begin
      mosi_q.delete(); miso_q.delete();
      tx_cnt = 0; rx_words = 0; rx_cnt = 0; pend = 0;
      at_if.at_oku_gecerli_g = 1'b0;
      at_if.at_oku_veri_g    = '0;
      at_if.at_mesgul_g      = 1'b0;
    end else begin
      at_if.at_oku_gecerli_g = pend && pend_ack;
      at_if.at_oku_veri_g    = pend ? pend_data : 32'h0;
      pend = 0;

      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0 && mosi_q.size() > 0) void'(mosi_q.pop_front());
      end
      if (rx_words > 0 && miso_q.size() < 8) begin
        if (rx_cnt > 0) rx_cnt--;
        else begin
          miso_q.push_back(slave_words.size() > 0 ? slave_words.pop_front() : 32'hBAD0_BAD0);
          rx_words--;
          rx_cnt = $urandom_range(6, 2);
        end
      end

      a = at_if.at_adres_c;
      d = at_if.at_yaz_veri_c;
      if (!at_if.at_gecerli_c) begin
        if (a !== A_PARK || at_if.at_yaz_gecerli_c !== 1'b0 || d !== 32'h0) park_err++;
        at_if.at_mesgul_g = busy_en && ($urandom_range(1, 0) == 1);
      end else begin
        busy = busy_en && (a == A_STATUS || a == A_RDATA || a == A_WDATA) &&
               ($urandom_range(3, 0) == 0);
        at_if.at_mesgul_g = busy;
        if (a == A_RDATA) rdata_req_cnt++;
        if (a == A_RDATA && veri_gecerli) rd_full_err++;
        if (a == A_WDATA) wdata_req_cnt++;
        pend = 1;
        if (busy) begin
          pend_ack  = ($urandom_range(1, 0) == 1);
          pend_data = $urandom;
        end else if (a == A_WDATA && drop_wdata) begin
          drop_wdata = 0;
          pend_ack   = 0;
          pend_data  = '0;
        end else begin
          pend_ack  = 1;
          pend_data = '0;
          if (at_if.at_yaz_gecerli_c) begin
            wr_log.push_back({a, d});
            if (a == A_CTRL && d[1]) begin
              mosi_q.delete(); miso_q.delete();
              tx_cnt = 0; rx_words = 0;
            end else if (a == A_WDATA) begin
              mosi_q.push_back(d);
              wdata_done_cnt++;
            end else if (a == A_CMD) begin
              if (d[13]) tx_cnt = $urandom_range(16, 6);
              if (d[12]) begin
                rx_words = int'(d[8:0]) / 4;
                rx_cnt   = $urandom_range(6, 2);
              end
            end
          end else if (a == A_STATUS) begin
            pend_data = {28'h0, miso_q.size() == 0, mosi_q.size() == 0,
                         miso_q.size() >= 8, mosi_q.size() >= 8};
          end else if (a == A_RDATA) begin
            pend_data = (miso_q.size() > 0) ? miso_q.pop_front() : 32'h0;
          end
        end
      end
    end
  end

  // Consumer: random ready, word scoreboard, hold stability and bitti shape.
  bit          prev_stall = 0, prev_bitti = 0;
  logic [31:0] prev_veri = '0;
  always @(negedge clk_g) begin
    if (!rst_g) begin
      veri_hazir = 1'b0;
      prev_stall = 0;
      prev_bitti = 0;
    end else begin
      if (prev_stall && (!veri_gecerli || veri !== prev_veri)) stab_err++;
      if (prev_bitti && (!istek_hazir || bitti)) hazir_err++;
      if (bitti) begin
        n_bitti++;
        rx_at_bitti = n_rx;
      end
      prev_bitti = bitti;
      veri_hazir = hold ? 1'b0 : ($urandom_range(3, 0) != 0);
      if (veri_gecerli && veri_hazir) begin
        if (exp_q.size() == 0) extra_err++;
        else check($sformatf("veri%0d", n_rx), 64'(veri), 64'(exp_q.pop_front()));
        n_rx++;
      end
      prev_stall = veri_gecerli && !veri_hazir;
      prev_veri  = veri;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_hazir"}, 64'(istek_hazir), 64'(1));
    check({tag, "_veri"},  64'({veri_gecerli, veri}), 64'(0));
    check({tag, "_bitti"}, 64'(bitti), 64'(0));
    check({tag, "_bus"},
          64'({at_if.at_gecerli_c, at_if.at_yaz_gecerli_c, at_if.at_adres_c, at_if.at_yaz_veri_c}),
          64'({2'b00, A_PARK, 32'h0}));
  endtask

  // mode 0: random words, 1: incrementing, 2: 0xDEADBEEF
  task automatic start_req(input logic [23:0] adr, input logic [6:0] n, input int mode);
    int t;
    logic [31:0] w;
    cur_k   = (n == 7'd0) ? 1 : int'(n);
    cur_adr = adr;
    for (int i = 0; i < cur_k; i++) begin
      w = (mode == 0) ? $urandom : (mode == 1) ? 32'hA500_0000 + i : 32'hDEAD_BEEF;
      slave_words.push_back(w);
      exp_q.push_back(w);
    end
    wr_log.delete();
    n_rx = 0; n_bitti = 0; rx_at_bitti = -1;
    wdata_req_cnt = 0; wdata_done_cnt = 0;
    t = 0;
    while (!istek_hazir && t < 100) begin @(negedge clk_g); t++; end
    check("hazir_bekle", 64'(istek_hazir), 64'(1));
    istek_gecerli = 1'b1;
    istek_adres   = adr;
    istek_sayi    = n;
    @(negedge clk_g);
    istek_gecerli = 1'b0;
    istek_adres   = 24'($urandom);
    istek_sayi    = 7'($urandom);
    check("hazir_dustu", 64'(istek_hazir), 64'(0));
    check("ilk_ctrl", 64'({at_if.at_gecerli_c, at_if.at_yaz_gecerli_c, at_if.at_adres_c}),
          64'({2'b11, A_CTRL}));
  endtask

  task automatic finish_req(input string tag);
    int t;
    logic [36:0] ew[5];
    ew[0] = {A_CTRL,  32'h0005_0001};
    ew[1] = {A_WDATA, 8'h03, cur_adr};
    ew[2] = {A_CMD,   32'h0000_2204};
    ew[3] = {A_CMD,   32'h0000_1200 | 32'(cur_k * 4)};
    ew[4] = {A_CTRL,  32'h0000_0002};
    t = 0;
    while (n_bitti == 0 && t < 20000) begin @(negedge clk_g); t++; end
    check({tag, "_bitti_zaman"}, 64'(n_bitti > 0), 64'(1));
    repeat (3) @(negedge clk_g);
    check({tag, "_bitti_adet"}, 64'(n_bitti), 64'(1));
    check({tag, "_bitti_sonra"}, 64'(rx_at_bitti), 64'(cur_k));
    check({tag, "_kelime"}, 64'(n_rx), 64'(cur_k));
    check({tag, "_kalan"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_hazir"}, 64'(istek_hazir), 64'(1));
    check({tag, "_yazma_adet"}, 64'(wr_log.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < wr_log.size()) check($sformatf("%s_yazma%0d", tag, i), 64'(wr_log[i]), 64'(ew[i]));
    check({tag, "_park"}, 64'(park_err), 64'(0));
    check({tag, "_rd_dolu"}, 64'(rd_full_err), 64'(0));
    check({tag, "_sabit"}, 64'(stab_err), 64'(0));
    check({tag, "_bitti_sekil"}, 64'(hazir_err), 64'(0));
    check({tag, "_fazla"}, 64'(extra_err), 64'(0));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, snap;
    repeat (3) @(negedge clk_g);
    check_reset("reset");
    rst_g = 1'b1;
    repeat (2) @(negedge clk_g);

    start_req(24'h012345, 7'd1, 2);
    finish_req("tek");

    start_req(24'h000100, 7'd10, 1);
    finish_req("burst");

    drop_wdata = 1;
    start_req(24'h0ABCDE, 7'd1, 0);
    finish_req("ack_kayip");
    check("wdata_istek", 64'(wdata_req_cnt), 64'(2));
    check("wdata_fifo", 64'(wdata_done_cnt), 64'(1));

    busy_en = 1;
    start_req(24'h400000, 7'd20, 0);
    t = 0;
    while (n_rx < 5 && t < 5000) begin @(negedge clk_g); t++; end
    hold = 1;
    t = 0;
    while (!veri_gecerli && t < 2000) begin @(negedge clk_g); t++; end
    check("bp_dolu", 64'(veri_gecerli), 64'(1));
    snap = rdata_req_cnt;
    repeat (200) @(negedge clk_g);
    check("bp_okuma", 64'(rdata_req_cnt - snap), 64'(0));
    check("bp_gecerli", 64'(veri_gecerli), 64'(1));
    hold = 0;
    finish_req("bp");

    for (int r = 0; r < 6; r++) begin
      start_req(24'($urandom), (r == 0) ? 7'd0 : 7'($urandom_range(12, 1)), 0);
      finish_req($sformatf("rnd%0d", r));
    end

    start_req(24'h777000, 7'd10, 1);
    t = 0;
    while (n_rx < 3 && t < 5000) begin @(negedge clk_g); t++; end
    check("rst_ara_kelime", 64'(n_rx >= 3), 64'(1));
    #2 rst_g = 1'b0;
    #1 check_reset("rst_ara");
    exp_q.delete();
    slave_words.delete();
    repeat (3) @(negedge clk_g);
    rst_g = 1'b1;
    repeat (2) @(negedge clk_g);
    start_req(24'h123456, 7'd5, 0);
    finish_req("rst_sonra");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
